// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I-subset core: XLEN, opcode/funct constants,
// the ALU operation enum and the funct3/funct7 to ALU-op mapping.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    // alt selects SUB/SRA; callers only raise it where that encoding is legal.
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: alu_from_funct = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_from_funct = ALU_SLL;
            F3_SLT:     alu_from_funct = ALU_SLT;
            F3_SLTU:    alu_from_funct = ALU_SLTU;
            F3_XOR:     alu_from_funct = ALU_XOR;
            F3_SRL_SRA: alu_from_funct = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_from_funct = ALU_OR;
            default:    alu_from_funct = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_cpu_single_cycle_if.sv
// Register-file access bundle between the core datapath and u_regfile.
// Reads are combinational; a write lands at the rising edge where we is high.
interface riscv_cpu_single_cycle_if;
    import riscv_pkg::*;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, rd_data,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data,
        output rs1_data, rs2_data
    );
endinterface

// File: rtl/riscv_cpu_single_cycle_imem.sv
// Instruction memory: word array with a combinational read port. Contents start
// at zero and are loaded from outside; reset never touches them.
module riscv_imem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   instr_o
);

    logic [31:0] imem [0:DEPTH-1] = '{default: '0};

    assign instr_o = imem[addr_i];

endmodule

// File: rtl/riscv_cpu_single_cycle_regfile.sv
// 32 x XLEN register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero, synchronous clear on reset.
module regfile
    import riscv_pkg::*;
(
    input logic                      clk,
    input logic                      rst,
    riscv_cpu_single_cycle_if.slave  rf
);

    logic [XLEN-1:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf.we && (rf.rd_addr != 5'd0)) begin
            regs[rf.rd_addr] <= rf.rd_data;
        end
    end

    // x0 reads as zero even if the array entry was poked from outside.
    assign rf.rs1_data = (rf.rs1_addr == 5'd0) ? '0 : regs[rf.rs1_addr];
    assign rf.rs2_data = (rf.rs2_addr == 5'd0) ? '0 : regs[rf.rs2_addr];

endmodule

// File: rtl/riscv_cpu_single_cycle.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and retire per clock.
// Define CPU_MEM_EN to add the data memory and enable LW/SW.
module riscv_cpu_single_cycle
    import riscv_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic rst
);

    localparam int IAW = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4, pc_target;
    logic [31:0]     instr;

    riscv_cpu_single_cycle_if rf_bus ();

    riscv_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) u_imem (
        .addr_i  (pc_q[IAW+1:2]),
        .instr_o (instr)
    );

    regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus.slave)
    );

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef CPU_MEM_EN
    logic [XLEN-1:0] imm_s;
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
`endif

    alu_op_e         alu_op;
    logic            alu_src_imm, wr_rd, is_branch, is_jal, is_load, is_store;
    logic [XLEN-1:0] imm;

    // Anything not explicitly recognised leaves every control low: a NOP.
    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        wr_rd       = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        imm         = imm_i;
        case (opcode)
            OP_REG: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))) begin
                    wr_rd  = 1'b1;
                    alu_op = alu_from_funct(funct3, funct7[5]);
                end
            end
            OP_IMM: begin
                if (!((funct3 == F3_SLL && funct7 != F7_ZERO) ||
                      (funct3 == F3_SRL_SRA && funct7 != F7_ZERO && funct7 != F7_ALT))) begin
                    wr_rd       = 1'b1;
                    alu_src_imm = 1'b1;
                    alu_op      = alu_from_funct(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
                end
            end
            OP_LUI: begin
                wr_rd       = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = ALU_PASS_B;
                imm         = imm_u;
            end
            OP_BRANCH: begin
                is_branch = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
                imm       = imm_b;
            end
            OP_JAL: begin
                wr_rd  = 1'b1;
                is_jal = 1'b1;
                imm    = imm_j;
            end
`ifdef CPU_MEM_EN
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    wr_rd       = 1'b1;
                    is_load     = 1'b1;
                    alu_src_imm = 1'b1;
                end
            end
            OP_STORE: begin
                is_store    = (funct3 == F3_WORD);
                alu_src_imm = 1'b1;
                imm         = imm_s;
            end
`endif
            default: ;
        endcase
    end

    logic [XLEN-1:0] op_a, op_b, alu_res;
    assign op_a = rf_bus.rs1_data;
    assign op_b = alu_src_imm ? imm : rf_bus.rs2_data;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_SLL:    alu_res = op_a << op_b[4:0];
            ALU_SLT:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'b0, op_a < op_b};
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SRL:    alu_res = op_a >> op_b[4:0];
            ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:     alu_res = op_a | op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = '0;
        endcase
    end

    logic [XLEN-1:0] load_data;
`ifdef CPU_MEM_EN
    localparam int DAW = $clog2(DMEM_DEPTH);
    logic [XLEN-1:0] dmem [0:DMEM_DEPTH-1];
    logic [DAW-1:0]  dmem_addr;
    assign dmem_addr = alu_res[DAW+1:2];
    assign load_data = dmem[dmem_addr];

    always_ff @(posedge clk) begin
        if (is_store && !rst) dmem[dmem_addr] <= rf_bus.rs2_data;
    end
`else
    localparam int unused_dmem_depth = DMEM_DEPTH;
    assign load_data = '0;
`endif

    assign rf_bus.rs1_addr = instr[19:15];
    assign rf_bus.rs2_addr = instr[24:20];
    assign rf_bus.we       = wr_rd && !rst;
    assign rf_bus.rd_addr  = rd;
    assign rf_bus.rd_data  = is_jal ? pc_plus4 : (is_load ? load_data : alu_res);

    logic branch_taken;
    // Only BEQ/BNE reach here; funct3[0] inverts the equality test for BNE.
    assign branch_taken = is_branch && ((rf_bus.rs1_data == rf_bus.rs2_data) ^ funct3[0]);
    assign pc_plus4     = pc_q + 32'd4;
    assign pc_target    = pc_q + imm;
    assign pc_d         = (branch_taken || is_jal) ? pc_target : pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) pc_q <= '0;
        else     pc_q <= pc_d;
    end

endmodule

// File: tb/tb_riscv_cpu_single_cycle.sv
// Directed-program bench for riscv_cpu_single_cycle: loads imem and registers
// hierarchically, runs a fixed number of cycles and checks architectural state.
module tb_riscv_cpu_single_cycle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    riscv_cpu_single_cycle #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk (clk),
        .rst (rst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.u_imem.imem[i] = 32'h0;
    endtask

    task automatic load_prog(input logic [31:0] words [$]);
        clear_imem();
        for (int i = 0; i < words.size(); i++) dut.u_imem.imem[i] = words[i];
    endtask

    task automatic set_reg(input int idx, input logic [31:0] v);
        dut.u_regfile.regs[idx] = v;
    endtask

    function automatic logic [31:0] get_reg(input int idx);
        return dut.u_regfile.regs[idx];
    endfunction

    function automatic logic [31:0] regs_or();
        logic [31:0] acc = 32'h0;
        for (int i = 0; i < 32; i++) acc |= dut.u_regfile.regs[i];
        return acc;
    endfunction

    initial begin
        logic [31:0] prog [$];

        // Reset clears registers and PC
        clear_imem();
        set_reg(5, 32'd123);
        do_reset();
        check("rst_regs", regs_or(), 32'h0);
        check("rst_pc", dut.pc_q, 32'h0);

        // ADD chain followed by zero (NOP) words
        prog = '{32'h002082B3, 32'h00328333};
        load_prog(prog);
        do_reset();
        set_reg(1, 32'd10); set_reg(2, 32'd20); set_reg(3, 32'd7);
        tick(10);
        check("add_x5", get_reg(5), 32'd30);
        check("add_x6", get_reg(6), 32'd37);
        check("add_x1_kept", get_reg(1), 32'd10);
        check("add_x4_zero", get_reg(4), 32'h0);
        check("add_x7_zero", get_reg(7), 32'h0);
        check("add_pc", dut.pc_q, 32'h28);

        // R-type signed/unsigned/shift mix
        prog = '{32'h402081B3, 32'h40115233, 32'h001122B3, 32'h00113333,
                 32'h0020C3B3, 32'h00115433, 32'h001094B3};
        load_prog(prog);
        do_reset();
        set_reg(1, 32'd5); set_reg(2, 32'hFFFFFFF8);
        tick(7);
        check("sub", get_reg(3), 32'd13);
        check("sra", get_reg(4), 32'hFFFFFFFF);
        check("slt", get_reg(5), 32'd1);
        check("sltu", get_reg(6), 32'd0);
        check("xor", get_reg(7), 32'hFFFFFFFD);
        check("srl", get_reg(8), 32'h07FFFFFF);
        check("sll", get_reg(9), 32'h000000A0);

        // x0, immediates, and an illegal (MUL) encoding
        prog = '{32'h00500013, 32'hFFF00393, 32'h12345437, 32'h0F03C513,
                 32'h4043D593, 32'h01C3D613, 32'h00103693, 32'h02738733};
        load_prog(prog);
        do_reset();
        tick(8);
        check("x0_stays", get_reg(0), 32'h0);
        check("addi_neg", get_reg(7), 32'hFFFFFFFF);
        check("lui", get_reg(8), 32'h12345000);
        check("xori", get_reg(10), 32'hFFFFFF0F);
        check("srai", get_reg(11), 32'hFFFFFFFF);
        check("srli", get_reg(12), 32'h0000000F);
        check("sltiu", get_reg(13), 32'd1);
        check("illegal_nop", get_reg(14), 32'h0);
        check("imm_pc", dut.pc_q, 32'h20);

        // beq skip, bne fall-through, jal backwards loop
        prog = '{32'h00108463, 32'h00100113, 32'h00001463, 32'h00118193, 32'hFFDFF0EF};
        load_prog(prog);
        do_reset();
        tick(4);
        check("beq_skip", get_reg(2), 32'h0);
        check("bne_fall", get_reg(3), 32'd1);
        check("jal_link", get_reg(1), 32'h14);
        check("jal_pc", dut.pc_q, 32'h0C);
        tick(2);
        check("loop_x3", get_reg(3), 32'd2);
        check("loop_pc", dut.pc_q, 32'h0C);

        // SW then LW through data memory
        prog = '{32'h00202223, 32'h00402483};
        load_prog(prog);
        do_reset();
        set_reg(2, 32'hDEADBEEF);
        tick(2);
`ifdef CPU_MEM_EN
        check("lw_data", get_reg(9), 32'hDEADBEEF);
        check("dmem_word", dut.dmem[1], 32'hDEADBEEF);
`else
        check("lw_nop", get_reg(9), 32'h0);
`endif
        check("mem_pc", dut.pc_q, 32'h08);

        // Reset in the middle of a program
        prog = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        load_prog(prog);
        do_reset();
        tick(3);
        check("pre_rst_x3", get_reg(3), 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_pc", dut.pc_q, 32'h0);
        check("mid_rst_regs", regs_or(), 32'h0);
        check("imem0_kept", dut.u_imem.imem[0], 32'h00100093);
        check("imem3_kept", dut.u_imem.imem[3], 32'h00400213);
        tick(1);
        check("restart_x1", get_reg(1), 32'd1);
        check("restart_pc", dut.pc_q, 32'h04);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_cpu_single_cycle.md
# riscv_cpu_single_cycle

Single-cycle RV32I-subset processor core: every instruction is fetched, decoded, executed and retired in one clock. It holds its own instruction memory, register file and (optionally) data memory, and has no external bus. Benches load programs and inspect results hierarchically. The core is the top-level compute block of the risc-v subsystem.

## Interface
- One clock; reset is synchronous and active-high.
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words.
- DMEM_DEPTH, 256: data memory depth in 32-bit words; used only with CPU_MEM_EN.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- The core has no other ports. Hierarchical access points are fixed:
  - Register file instance `u_regfile`, array `regs[0:31]` of 32-bit words.
  - Instruction memory instance `u_imem`, array `imem[0:IMEM_DEPTH-1]` of 32-bit words.

## Operation
- PC is 32 bits. Fetch uses `imem[PC[31:2]]`; PC bits above the IMEM_DEPTH index range are ignored, so addresses wrap.
- All `imem` entries initialise to 0 at time zero. Reset does not alter `imem`.
- Supported instructions:
  - R-type (opcode 0110011): ADD, SUB (funct7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type ALU (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI (0110111).
  - BEQ, BNE (1100011).
  - JAL (1101111): rd ← PC+4.
  - With CPU_MEM_EN also: LW (0000011) and SW (0100011).
- All arithmetic is 32-bit two's complement and wraps. Immediates are sign-extended. Shift amount is the low 5 bits.
- Register x0 always reads 0; writes to x0 are discarded.
- Any unsupported or illegal encoding, including 0x00000000, is a NOP: no register or memory write, PC ← PC+4.
- Next PC is PC+imm for a taken branch or JAL, otherwise PC+4.

## Timing
- Reset asserted at a rising edge:
  - PC ← 0.
  - All `regs` ← 0.
  - Data memory is not cleared.
  - No instruction retires in that cycle.
- First cycle after reset deasserts: the rising edge retires `imem[0]`.
- Each later edge retires exactly one instruction: latency 1 cycle, CPI 1.
- Register file: two combinational read ports, one synchronous write port. A read of a register written in the same cycle returns the old value.
- Register-file, memory and PC values changed hierarchically between edges take effect at the next edge.
- LW data is read combinationally and written back at the same edge. SW writes at the edge.
- Reset mid-program: the PC returns to 0 at that edge, overriding any branch in flight.

## Configuration
- CPU_MEM_EN defined: data memory `dmem[0:DMEM_DEPTH-1]` is present and LW/SW execute. Word-aligned only; address bits [1:0] are ignored.
- CPU_MEM_EN undefined: no data memory exists, and LW/SW decode as NOPs.

## Structure
- Shared package `riscv_pkg` holds:
  - Opcode constants.
  - funct3/funct7 constants.
  - ALU-operation enum typedef.
  - XLEN=32.
- Natural sub-module: `regfile`, instantiated as `u_regfile`.
- Instruction memory is a small leaf module instantiated as `u_imem`.
- ALU, decoder, immediate generator and PC logic stay in the top module.

## Test plan
- ADD chain: reset 1 cycle, preload x1=10, x2=20, x3=7, `imem[0]`=0x002082B3 (add x5,x1,x2), `imem[1]`=0x00328333 (add x6,x5,x3), run 10 cycles → x5=30, x6=37, and zero words after them leave all registers unchanged.
- SUB/SRA/SLT: x1=5, x2=-8 → sub x3,x1,x2 = 13; sra x4,x2,x1 (shift 5) = -1; slt x5,x2,x1 = 1; sltu x6,x2,x1 = 0.
- x0 and immediates: addi x0,x0,5 → x0 stays 0; addi x7,x0,-1 → 0xFFFFFFFF; lui x8,0x12345 → 0x12345000.
- Branch/JAL:
  - beq x1,x1,+8 skips the next instruction.
  - bne on equal operands falls through.
  - jal x1,-4 at PC 0x10 gives x1=0x14 and PC=0x0C.
- Memory (CPU_MEM_EN): sw x2,4(x0) with x2=0xDEADBEEF, then lw x9,4(x0) → x9=0xDEADBEEF. Without the macro, x9 stays 0.
- Reset mid-run: assert rst after 3 retired instructions → next edge PC=0 and all regs=0; `imem` contents are preserved.
